// File: rtl/rot_pkg.sv
// Shared widths and FSM state encoding for the rotation-alignment search.
package rot_pkg;
    localparam int ROT_W = 32;
    localparam int SH_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/rot_align_32.sv
// Finds smallest k with rotl(pattern,k)==data_in; result k+1 cycles after start (32 if no match).
// Start is only accepted in IDLE; requests while busy (SEARCH/DONE) are dropped, not queued.
module rot_align_32
    import rot_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ROT_W-1:0]    data_in,
    input  logic [ROT_W-1:0]    pattern,
    output logic                busy,
    output logic                done,
    output logic                found,
    output logic [SH_W-1:0]     sh_l,
    output logic [SH_W-1:0]     sh_r
);

    state_t             state;
    state_t             state_nxt;
    logic [ROT_W-1:0]   cand;
    logic [ROT_W-1:0]   pat;
    logic [SH_W-1:0]    k;
    logic               hit;
    logic               last;

    assign hit  = (cand == pat);
    assign last = (k == SH_W'(ROT_W - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = ST_SEARCH;
            ST_SEARCH: if (hit || last) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cand  <= '0;
            pat   <= '0;
            k     <= '0;
            found <= 1'b0;
            sh_l  <= '0;
            sh_r  <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        cand  <= data_in;
                        pat   <= pattern;
                        k     <= '0;
                        found <= 1'b0;
                    end
                end
                ST_SEARCH: begin
                    // Compare wins over the k==31 limit so a match at the last step is still reported.
                    if (hit) begin
                        sh_l  <= k;
                        sh_r  <= SH_W'(0) - k;
                        found <= 1'b1;
                    end else if (last) begin
                        sh_l  <= '0;
                        sh_r  <= '0;
                        found <= 1'b0;
                    end else begin
                        cand <= {cand[0], cand[ROT_W-1:1]};
                        k    <= k + SH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_rot_align_32.sv
// Directed self-checking bench for rot_align_32: latency, results, handshake and reset behaviour.
module tb_rot_align_32;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] data_in;
    logic [31:0] pattern;
    logic        busy;
    logic        done;
    logic        found;
    logic [4:0]  sh_l;
    logic [4:0]  sh_r;

    int errors = 0;
    int checks = 0;

    rot_align_32 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .pattern (pattern),
        .busy    (busy),
        .done    (done),
        .found   (found),
        .sh_l    (sh_l),
        .sh_r    (sh_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request and returns cycles from acceptance to done plus busy-cycle count.
    task automatic run_req(input logic [31:0] d, input logic [31:0] p,
                           output int lat, output int bcnt);
        @(negedge clk);
        data_in = d;
        pattern = p;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        bcnt  = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        start   = 1'b0;
        data_in = '0;
        pattern = '0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (found !== 1'b0) begin errors++; $display("FAIL reset_found got=%b exp=0", found); end
        checks++; if (sh_l !== 5'd0)  begin errors++; $display("FAIL reset_sh_l got=%0d exp=0", sh_l); end
        checks++; if (sh_r !== 5'd0)  begin errors++; $display("FAIL reset_sh_r got=%0d exp=0", sh_r); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_shift8();
        int lat, bcnt;
        run_req(32'h0000_0100, 32'h0000_0001, lat, bcnt);
        checks++; if (lat !== 9)      begin errors++; $display("FAIL shift8_latency got=%0d exp=9", lat); end
        checks++; if (bcnt !== 10)    begin errors++; $display("FAIL shift8_busy_cycles got=%0d exp=10", bcnt); end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL shift8_found got=%b exp=1", found); end
        checks++; if (sh_l !== 5'd8)  begin errors++; $display("FAIL shift8_sh_l got=%0d exp=8", sh_l); end
        checks++; if (sh_r !== 5'd24) begin errors++; $display("FAIL shift8_sh_r got=%0d exp=24", sh_r); end
        @(negedge clk);
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL shift8_done_pulse got=%b exp=0", done); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL shift8_busy_after got=%b exp=0", busy); end
        checks++; if (sh_l !== 5'd8 || found !== 1'b1)
            begin errors++; $display("FAIL shift8_hold got sh_l=%0d found=%b exp sh_l=8 found=1", sh_l, found); end
    endtask

    task automatic test_no_match();
        int lat, bcnt;
        run_req(32'h0000_0003, 32'h0000_0001, lat, bcnt);
        checks++; if (lat !== 32)     begin errors++; $display("FAIL nomatch_latency got=%0d exp=32", lat); end
        checks++; if (found !== 1'b0) begin errors++; $display("FAIL nomatch_found got=%b exp=0", found); end
        checks++; if (sh_l !== 5'd0)  begin errors++; $display("FAIL nomatch_sh_l got=%0d exp=0", sh_l); end
        checks++; if (sh_r !== 5'd0)  begin errors++; $display("FAIL nomatch_sh_r got=%0d exp=0", sh_r); end
    endtask

    task automatic test_periodic();
        int lat, bcnt;
        run_req(32'h5555_5555, 32'hAAAA_AAAA, lat, bcnt);
        checks++; if (lat !== 2)      begin errors++; $display("FAIL periodic_latency got=%0d exp=2", lat); end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL periodic_found got=%b exp=1", found); end
        checks++; if (sh_l !== 5'd1)  begin errors++; $display("FAIL periodic_sh_l got=%0d exp=1", sh_l); end
        checks++; if (sh_r !== 5'd31) begin errors++; $display("FAIL periodic_sh_r got=%0d exp=31", sh_r); end
        run_req(32'h0000_0001, 32'h8000_0000, lat, bcnt);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL msb_found got=%b exp=1", found); end
        checks++; if (sh_l !== 5'd1)  begin errors++; $display("FAIL msb_sh_l got=%0d exp=1", sh_l); end
        checks++; if (sh_r !== 5'd31) begin errors++; $display("FAIL msb_sh_r got=%0d exp=31", sh_r); end
    endtask

    task automatic test_identical();
        int lat, bcnt;
        run_req(32'hDEAD_BEEF, 32'hDEAD_BEEF, lat, bcnt);
        checks++; if (lat !== 1)      begin errors++; $display("FAIL ident_latency got=%0d exp=1", lat); end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL ident_found got=%b exp=1", found); end
        checks++; if (sh_l !== 5'd0)  begin errors++; $display("FAIL ident_sh_l got=%0d exp=0", sh_l); end
        checks++; if (sh_r !== 5'd0)  begin errors++; $display("FAIL ident_sh_r got=%0d exp=0", sh_r); end
    endtask

    task automatic test_back_to_back();
        int lat, lat2;
        @(negedge clk);
        data_in = 32'h0000_0100;
        pattern = 32'h0000_0001;
        start   = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            data_in = ~data_in;
            pattern = pattern ^ 32'h0F0F_0F0F;
        end
        checks++; if (lat !== 9)      begin errors++; $display("FAIL held_latency got=%0d exp=9", lat); end
        checks++; if (found !== 1'b1 || sh_l !== 5'd8 || sh_r !== 5'd24)
            begin errors++; $display("FAIL held_result got found=%b sh_l=%0d sh_r=%0d exp 1/8/24", found, sh_l, sh_r); end
        data_in = 32'h0000_0004;
        pattern = 32'h0000_0001;
        @(negedge clk);
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL held_idle_gap got=%b exp=0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || found !== 1'b0)
            begin errors++; $display("FAIL held_accept got busy=%b found=%b exp busy=1 found=0", busy, found); end
        lat2 = -1;
        for (int n = 1; n < 40; n++) begin
            @(negedge clk);
            if (done) begin
                lat2 = n;
                break;
            end
        end
        start = 1'b0;
        checks++; if (lat2 !== 3)     begin errors++; $display("FAIL held2_latency got=%0d exp=3", lat2); end
        checks++; if (sh_l !== 5'd2 || sh_r !== 5'd30)
            begin errors++; $display("FAIL held2_result got sh_l=%0d sh_r=%0d exp 2/30", sh_l, sh_r); end
    endtask

    task automatic test_mid_reset();
        int lat, bcnt;
        @(negedge clk);
        data_in = 32'h0000_0100;
        pattern = 32'h0000_0001;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || sh_l !== 5'd0 || sh_r !== 5'd0)
            begin errors++; $display("FAIL midrst_clear got busy=%b done=%b found=%b sh_l=%0d sh_r=%0d exp all 0",
                                     busy, done, found, sh_l, sh_r); end
        @(negedge clk);
        rst_n = 1'b1;
        run_req(32'h8000_0000, 32'h0000_0001, lat, bcnt);
        checks++; if (lat !== 32)     begin errors++; $display("FAIL k31_latency got=%0d exp=32", lat); end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL k31_found got=%b exp=1", found); end
        checks++; if (sh_l !== 5'd31) begin errors++; $display("FAIL k31_sh_l got=%0d exp=31", sh_l); end
        checks++; if (sh_r !== 5'd1)  begin errors++; $display("FAIL k31_sh_r got=%0d exp=1", sh_r); end
    endtask

    initial begin
        test_reset();
        test_shift8();
        test_no_match();
        test_periodic();
        test_identical();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
